// File: rtl/uxn_stack_unit.sv
// rtl/uxn_stack_unit.sv - byte/short hardware stack behind valid/ready request and response channels
//
// Purpose: responder for the stack CPU's push/pop traffic. Holds 2^DEPTH_LOG2
// bytes in a flop array and moves 8-bit or 16-bit (big-endian) values. It
// rejects operations that would overflow or underflow, and keeps sticky
// debug flags for those errors.
//
// Ports:
//   clk, rst                       clock; asynchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_push, req_short, req_keep  operation: push/pop, 16/8-bit, non-consuming pop
//   req_wdata[15:0]                push data (byte ops use [7:0])
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata[15:0], rsp_err       pop data (zero-extended for bytes), rejection flag
//   level[DEPTH_LOG2:0]            bytes currently on the stack
//   err_ovf, err_udf, err_clr      sticky overflow/underflow flags and their clear
//
// Optional feature macro: UXN_STACK_KEEP_EN enables req_keep (a pop that leaves
// level unchanged). When the macro is undefined, req_keep is ignored.

module uxn_stack_unit #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_push,
  input  logic                  req_short,
  input  logic                  req_keep,
  input  logic [15:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  err_ovf,
  output logic                  err_udf,
  input  logic                  err_clr
);

  localparam int CAP = 1 << DEPTH_LOG2;
  // Capacity expressed in one bit more than level, so level + 2 cannot wrap.
  localparam logic [DEPTH_LOG2+1:0] CAP_W = {2'b01, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  op_push;
  logic                  op_short;
  logic [15:0]           op_wdata;
  logic [15:0]           rdata_q;
  logic                  err_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic [7:0]            mem [0:CAP-1];

  logic [DEPTH_LOG2:0]   n_lvl;
  logic                  push_fit;
  logic                  pop_fit;
  logic                  op_ok;
  logic                  consume;
  logic [DEPTH_LOG2:0]   level_step;
  logic [DEPTH_LOG2-1:0] addr_l;
  logic [DEPTH_LOG2-1:0] addr_p1;
  logic [DEPTH_LOG2-1:0] addr_m1;
  logic [DEPTH_LOG2-1:0] addr_m2;
  logic                  ovf_set;
  logic                  udf_set;

`ifdef UXN_STACK_KEEP_EN
  logic                  op_keep;
  // Pushes always move level; pops move it unless they are keep-pops.
  assign consume = op_push | ~op_keep;
`else
  logic                  keep_unused;
  assign keep_unused = req_keep;
  assign consume     = 1'b1;
`endif

  // Bytes moved by the latched operation.
  assign n_lvl = op_short ? {{(DEPTH_LOG2-1){1'b0}}, 2'd2}
                          : {{DEPTH_LOG2{1'b0}}, 1'b1};

  assign push_fit = ({1'b0, level_q} + {1'b0, n_lvl}) <= CAP_W;
  assign pop_fit  = level_q >= n_lvl;
  assign op_ok    = op_push ? push_fit : pop_fit;

  assign level_step = op_push ? (level_q + n_lvl) : (level_q - n_lvl);

  // Level does not move until the operation completes, so every access is
  // addressed relative to the level captured at acceptance.
  assign addr_l  = level_q[DEPTH_LOG2-1:0];
  assign addr_p1 = addr_l + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  assign addr_m1 = addr_l - {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  assign addr_m2 = addr_l - {{(DEPTH_LOG2-2){1'b0}}, 2'd2};

  assign ovf_set = (state == ACC0) &  op_push & ~push_fit;
  assign udf_set = (state == ACC0) & ~op_push & ~pop_fit;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign level     = level_q;
  assign err_ovf   = ovf_q;
  assign err_udf   = udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = ACC0;
        end
      end
      ACC0: begin
        if (!op_ok || !op_short) begin
          state_nxt = RESP;
        end else begin
          state_nxt = ACC1;
        end
      end
      ACC1: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_push  <= 1'b0;
      op_short <= 1'b0;
      op_wdata <= 16'h0000;
`ifdef UXN_STACK_KEEP_EN
      op_keep  <= 1'b0;
`endif
      rdata_q  <= 16'h0000;
      err_q    <= 1'b0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      // A clear wins over a set in the same cycle.
      if (err_clr) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q | ovf_set;
        udf_q <= udf_q | udf_set;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            op_push  <= req_push;
            op_short <= req_short;
            op_wdata <= req_wdata;
`ifdef UXN_STACK_KEEP_EN
            op_keep  <= req_keep;
`endif
            // Pushes and rejected ops report zero data.
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
          end
        end
        ACC0: begin
          if (!op_ok) begin
            err_q <= 1'b1;
          end else begin
            if (!op_push) begin
              rdata_q[7:0] <= mem[addr_m1];
            end
            if (!op_short && consume) begin
              level_q <= level_step;
            end
          end
        end
        ACC1: begin
          if (!op_push) begin
            rdata_q[15:8] <= mem[addr_m2];
          end
          if (consume) begin
            level_q <= level_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage is not reset. Stale bytes are harmless because level bounds
  // every read.
  always_ff @(posedge clk) begin
    if (state == ACC0 && op_ok && op_push) begin
      mem[addr_l] <= op_short ? op_wdata[15:8] : op_wdata[7:0];
    end
    if (state == ACC1 && op_push) begin
      mem[addr_p1] <= op_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_uxn_stack_unit.sv
// tb/tb_uxn_stack_unit.sv - directed self-checking bench for uxn_stack_unit

module tb_uxn_stack_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_push;
  logic        req_short;
  logic        req_keep;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [8:0]  level;
  logic        err_ovf;
  logic        err_udf;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  uxn_stack_unit #(.DEPTH_LOG2(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_push  (req_push),
    .req_short (req_short),
    .req_keep  (req_keep),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .level     (level),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction with rsp_ready high. lat counts the edges after the
  // acceptance edge up to the first edge at which rsp_valid is seen high.
  task automatic do_op(input logic push, input logic short_op, input logic keep,
                       input logic [15:0] wd, output logic [15:0] rd,
                       output logic er, output int lat);
    @(negedge clk);
    req_push  = push;
    req_short = short_op;
    req_keep  = keep;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat;
  int          err_count;
  int          lvl_exp;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_push  = 1'b0;
    req_short = 1'b0;
    req_keep  = 1'b0;
    req_wdata = 16'h0000;
    rsp_ready = 1'b1;
    err_clr   = 1'b0;
    apply_reset();

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_err_ovf",   32'(err_ovf),   32'd0);
    check("rst_err_udf",   32'(err_udf),   32'd0);

    // Byte round trip.
    do_op(1'b1, 1'b0, 1'b0, 16'h0012, rd, er, lat);
    check("pushb_err",   32'(er),    32'd0);
    check("pushb_lat",   32'(lat),   32'd2);
    check("pushb_level", 32'(level), 32'd1);
    do_op(1'b0, 1'b0, 1'b0, 16'h0000, rd, er, lat);
    check("popb_data",  32'(rd),    32'h0012);
    check("popb_err",   32'(er),    32'd0);
    check("popb_lat",   32'(lat),   32'd2);
    check("popb_level", 32'(level), 32'd0);

    // Short ordering and mixed widths.
    do_op(1'b1, 1'b1, 1'b0, 16'hABCD, rd, er, lat);
    check("pushs_lat",   32'(lat),   32'd3);
    check("pushs_level", 32'(level), 32'd2);
    check("pushs_data",  32'(rd),    32'h0000);
    do_op(1'b0, 1'b0, 1'b0, 16'h0000, rd, er, lat);
    check("mix_lo_data",  32'(rd),    32'h00CD);
    check("mix_lo_level", 32'(level), 32'd1);
    do_op(1'b0, 1'b0, 1'b0, 16'h0000, rd, er, lat);
    check("mix_hi_data",  32'(rd),    32'h00AB);
    check("mix_hi_level", 32'(level), 32'd0);
    do_op(1'b1, 1'b1, 1'b0, 16'h1234, rd, er, lat);
    do_op(1'b0, 1'b1, 1'b0, 16'h0000, rd, er, lat);
    check("pops_data",  32'(rd),    32'h1234);
    check("pops_err",   32'(er),    32'd0);
    check("pops_lat",   32'(lat),   32'd3);
    check("pops_level", 32'(level), 32'd0);

    // Keep-pop.
    do_op(1'b1, 1'b0, 1'b0, 16'h0055, rd, er, lat);
    do_op(1'b0, 1'b0, 1'b1, 16'h0000, rd, er, lat);
    check("keep_data", 32'(rd), 32'h0055);
`ifdef UXN_STACK_KEEP_EN
    lvl_exp = 1;
`else
    lvl_exp = 0;
`endif
    check("keep_level", 32'(level), 32'(lvl_exp));

    // Underflow: one byte on the stack, short pop rejected.
    apply_reset();
    do_op(1'b1, 1'b0, 1'b0, 16'h0077, rd, er, lat);
    do_op(1'b0, 1'b1, 1'b0, 16'h0000, rd, er, lat);
    check("udf_err",   32'(er),      32'd1);
    check("udf_data",  32'(rd),      32'h0000);
    check("udf_lat",   32'(lat),     32'd2);
    check("udf_flag",  32'(err_udf), 32'd1);
    check("udf_ovf",   32'(err_ovf), 32'd0);
    check("udf_level", 32'(level),   32'd1);

    // Overflow: fill all 256 bytes, then one more push.
    apply_reset();
    check("clr_on_rst_udf", 32'(err_udf), 32'd0);
    err_count = 0;
    for (int i = 0; i < 256; i++) begin
      do_op(1'b1, 1'b0, 1'b0, 16'(i), rd, er, lat);
      if (er) err_count++;
    end
    check("fill_errs",  32'(err_count), 32'd0);
    check("fill_level", 32'(level),     32'd256);
    check("fill_ovf",   32'(err_ovf),   32'd0);
    do_op(1'b1, 1'b0, 1'b0, 16'h00EE, rd, er, lat);
    check("ovf_err",   32'(er),      32'd1);
    check("ovf_flag",  32'(err_ovf), 32'd1);
    check("ovf_level", 32'(level),   32'd256);
    check("ovf_data",  32'(rd),      32'h0000);
    // A short push at 255 must also be rejected.
    do_op(1'b0, 1'b0, 1'b0, 16'h0000, rd, er, lat);
    check("top_data", 32'(rd), 32'h00FF);
    do_op(1'b1, 1'b1, 1'b0, 16'h1111, rd, er, lat);
    check("ovf_short_err",   32'(er),    32'd1);
    check("ovf_short_level", 32'(level), 32'd255);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_ovf", 32'(err_ovf), 32'd0);
    check("clr_udf", 32'(err_udf), 32'd0);

    // Backpressure: response held with rsp_ready low.
    apply_reset();
    do_op(1'b1, 1'b0, 1'b0, 16'h003C, rd, er, lat);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_push  = 1'b0;
    req_short = 1'b0;
    req_keep  = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp_ready_acc0", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data",  32'(rsp_rdata), 32'h003C);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done_ready", 32'(req_ready), 32'd1);
    check("bp_done_level", 32'(level),     32'd0);

    // Reset during ACC1 of a short push.
    do_op(1'b1, 1'b0, 1'b0, 16'h0099, rd, er, lat);
    check("pre_rst_level", 32'(level), 32'd1);
    @(negedge clk);
    req_push  = 1'b1;
    req_short = 1'b1;
    req_wdata = 16'hBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_level", 32'(level),     32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 1'b0, 1'b0, 16'h0000, rd, er, lat);
    check("post_rst_pop_err",  32'(er), 32'd1);
    check("post_rst_pop_data", 32'(rd), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
